// File: rtl/sparc_ifu_imdctl_if.sv
// D-stage immediate/branch-offset control bus between the fetch/decode unit and imdctl.
interface sparc_ifu_imdctl_if;
   // inputs to the controller
   logic [31:0] dtu_inst_d;
   logic        fcl_imdctl_vld_d;
   logic [1:0]  fcl_imdctl_thr_d;
   logic        fcl_imdctl_flush_e;
   logic        fcl_imdctl_flush_m;
   logic        tlu_cwp_wr_vld;
   logic [1:0]  tlu_cwp_wr_thr;
   logic [2:0]  tlu_cwp_wr_data;
   // outputs from the controller
   logic        dcl_imd_immdata_sel_simm13_d_l;
   logic        dcl_imd_immdata_sel_movcc_d_l;
   logic        dcl_imd_immdata_sel_movr_d_l;
   logic        dcl_imd_immdata_sel_sethi_d_l;
   logic        dcl_imd_broff_sel_call_d_l;
   logic        dcl_imd_broff_sel_br_d_l;
   logic        dcl_imd_broff_sel_bcc_d_l;
   logic        dcl_imd_broff_sel_bpcc_d_l;
   logic        dcl_imd_immbr_sel_br_d;
   logic        dcl_imd_call_inst_d;
   logic        fcl_imd_oddwin_d;
   logic        imdctl_stall_d;
   logic [2:0]  imdctl_cwp_d;

   // driver side (decode/fetch control, TLU)
   modport master (
      output dtu_inst_d, fcl_imdctl_vld_d, fcl_imdctl_thr_d,
             fcl_imdctl_flush_e, fcl_imdctl_flush_m,
             tlu_cwp_wr_vld, tlu_cwp_wr_thr, tlu_cwp_wr_data,
      input  dcl_imd_immdata_sel_simm13_d_l, dcl_imd_immdata_sel_movcc_d_l,
             dcl_imd_immdata_sel_movr_d_l, dcl_imd_immdata_sel_sethi_d_l,
             dcl_imd_broff_sel_call_d_l, dcl_imd_broff_sel_br_d_l,
             dcl_imd_broff_sel_bcc_d_l, dcl_imd_broff_sel_bpcc_d_l,
             dcl_imd_immbr_sel_br_d, dcl_imd_call_inst_d,
             fcl_imd_oddwin_d, imdctl_stall_d, imdctl_cwp_d
   );

   // controller side
   modport slave (
      input  dtu_inst_d, fcl_imdctl_vld_d, fcl_imdctl_thr_d,
             fcl_imdctl_flush_e, fcl_imdctl_flush_m,
             tlu_cwp_wr_vld, tlu_cwp_wr_thr, tlu_cwp_wr_data,
      output dcl_imd_immdata_sel_simm13_d_l, dcl_imd_immdata_sel_movcc_d_l,
             dcl_imd_immdata_sel_movr_d_l, dcl_imd_immdata_sel_sethi_d_l,
             dcl_imd_broff_sel_call_d_l, dcl_imd_broff_sel_br_d_l,
             dcl_imd_broff_sel_bcc_d_l, dcl_imd_broff_sel_bpcc_d_l,
             dcl_imd_immbr_sel_br_d, dcl_imd_call_inst_d,
             fcl_imd_oddwin_d, imdctl_stall_d, imdctl_cwp_d
   );
endinterface

// File: rtl/sparc_ifu_imdctl.sv
// D-stage immediate/branch-offset mux control, per-thread committed CWP
// tracking through a D/E/M/W shadow pipeline, and window-op hazard stall.
module sparc_ifu_imdctl #(
   parameter int unsigned NTHR = 4,
   parameter int unsigned CWPW = 3
) (
   input  logic                rclk,
   input  logic                reset,
   input  logic                se,
   input  logic                si,
   output logic                so,
   sparc_ifu_imdctl_if.slave   imd
);

   localparam int unsigned TW    = 2;
   localparam int unsigned STW   = 1 + TW + 2;
   localparam int unsigned NBITS = 3 * STW + NTHR * CWPW;

   typedef struct packed {
      logic          vld;
      logic [TW-1:0] thr;
      logic          save;
      logic          rest;
   } stg_t;

   logic [31:0] inst;
   logic [1:0]  op;
   logic [2:0]  op2;
   logic [5:0]  op3;
   logic        unused_inst_bits;

   assign inst             = imd.dtu_inst_d;
   assign op               = inst[31:30];
   assign op2              = inst[24:22];
   assign op3              = inst[24:19];
   assign unused_inst_bits = ^{inst[29:25], inst[18:0]};

   // ---------------------------------------------------------------
   // Decode: one-hot (active-high internally) select groups
   // ---------------------------------------------------------------
   logic sel_simm13_c, sel_movcc_c, sel_movr_c, sel_sethi_c;
   logic br_call_c, br_br_c, br_bcc_c, br_bpcc_c;
   logic immbr_c, call_c;

   // Mux select decode; defaults keep each group exactly one-hot for any encoding
   always_comb begin
      sel_simm13_c = 1'b1;
      sel_movcc_c  = 1'b0;
      sel_movr_c   = 1'b0;
      sel_sethi_c  = 1'b0;
      br_call_c    = 1'b1;
      br_br_c      = 1'b0;
      br_bcc_c     = 1'b0;
      br_bpcc_c    = 1'b0;
      immbr_c      = 1'b0;
      call_c       = 1'b0;
      case (op)
         2'b01: begin
            immbr_c = 1'b1;
            call_c  = 1'b1;
         end
         2'b00: begin
            case (op2)
               3'b011: begin
                  br_call_c = 1'b0;
                  br_br_c   = 1'b1;
                  immbr_c   = 1'b1;
               end
               3'b010, 3'b110: begin
                  br_call_c = 1'b0;
                  br_bcc_c  = 1'b1;
                  immbr_c   = 1'b1;
               end
               3'b001, 3'b101: begin
                  br_call_c = 1'b0;
                  br_bpcc_c = 1'b1;
                  immbr_c   = 1'b1;
               end
               3'b100: begin
                  sel_simm13_c = 1'b0;
                  sel_sethi_c  = 1'b1;
               end
               default: ;
            endcase
         end
         2'b10: begin
            if (op3 == 6'b101100) begin
               sel_simm13_c = 1'b0;
               sel_movcc_c  = 1'b1;
            end else if (op3 == 6'b101111) begin
               sel_simm13_c = 1'b0;
               sel_movr_c   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign imd.dcl_imd_immdata_sel_simm13_d_l = ~sel_simm13_c;
   assign imd.dcl_imd_immdata_sel_movcc_d_l  = ~sel_movcc_c;
   assign imd.dcl_imd_immdata_sel_movr_d_l   = ~sel_movr_c;
   assign imd.dcl_imd_immdata_sel_sethi_d_l  = ~sel_sethi_c;
   assign imd.dcl_imd_broff_sel_call_d_l     = ~br_call_c;
   assign imd.dcl_imd_broff_sel_br_d_l       = ~br_br_c;
   assign imd.dcl_imd_broff_sel_bcc_d_l      = ~br_bcc_c;
   assign imd.dcl_imd_broff_sel_bpcc_d_l     = ~br_bpcc_c;
   assign imd.dcl_imd_immbr_sel_br_d         = immbr_c;
   assign imd.dcl_imd_call_inst_d            = call_c;

   // ---------------------------------------------------------------
   // Window-op detection and state flops (single chain for scan)
   // ---------------------------------------------------------------
   logic save_d, rest_d;
   assign save_d = (op == 2'b10) && (op3 == 6'b111100);
   assign rest_d = (op == 2'b10) && ((op3 == 6'b111101) || (op3 == 6'b111001));

   logic [NBITS-1:0]           flops_q, flops_d, func_d;
   stg_t                       stg_e_q, stg_m_q, stg_w_q;
   stg_t                       stg_e_d, stg_m_d, stg_w_d;
   logic [NTHR-1:0][CWPW-1:0]  cwp_q, cwp_d;

   assign {stg_e_q, stg_m_q, stg_w_q, cwp_q} = flops_q;
   assign func_d = {stg_e_d, stg_m_d, stg_w_d, cwp_d};
   assign so     = flops_q[NBITS-1];

   // ---------------------------------------------------------------
   // Stall: same-thread window op anywhere in E/M/W
   // ---------------------------------------------------------------
   logic [TW-1:0] thr_d;
   logic          vld_d_c, hit_e_c, hit_m_c, hit_w_c, stall_c;

   assign thr_d   = imd.fcl_imdctl_thr_d;
   assign vld_d_c = imd.fcl_imdctl_vld_d & ~reset;
   assign hit_e_c = stg_e_q.vld & (stg_e_q.save | stg_e_q.rest) & (stg_e_q.thr == thr_d);
   assign hit_m_c = stg_m_q.vld & (stg_m_q.save | stg_m_q.rest) & (stg_m_q.thr == thr_d);
   assign hit_w_c = stg_w_q.vld & (stg_w_q.save | stg_w_q.rest) & (stg_w_q.thr == thr_d);
   assign stall_c = vld_d_c & (hit_e_c | hit_m_c | hit_w_c);

   assign imd.imdctl_stall_d = stall_c;

   // Shadow pipeline advance; a stalled D instruction leaves a bubble in E
   always_comb begin
      stg_e_d      = '{vld: vld_d_c & ~stall_c, thr: thr_d, save: save_d, rest: rest_d};
      stg_m_d      = stg_e_q;
      stg_m_d.vld  = stg_e_q.vld & ~imd.fcl_imdctl_flush_e;
      stg_w_d      = stg_m_q;
      stg_w_d.vld  = stg_m_q.vld & ~imd.fcl_imdctl_flush_m;
   end

   // CWP commit from W, overridden by a TLU write to the same thread
   always_comb begin
      cwp_d = cwp_q;
      for (int t = 0; t < int'(NTHR); t++) begin
         if (stg_w_q.vld && (stg_w_q.thr == TW'(t))) begin
            if (stg_w_q.save)
               cwp_d[t] = cwp_q[t] + CWPW'(1);
            else if (stg_w_q.rest)
               cwp_d[t] = cwp_q[t] - CWPW'(1);
         end
         if (imd.tlu_cwp_wr_vld && (imd.tlu_cwp_wr_thr == TW'(t)))
            cwp_d[t] = CWPW'(imd.tlu_cwp_wr_data);
      end
   end

   // Scan shifts the whole state chain; otherwise take the functional next state
   assign flops_d = se ? {flops_q[NBITS-2:0], si} : func_d;

   // State register with synchronous reset that also discards in-flight entries
   always_ff @(posedge rclk) begin
      if (reset)
         flops_q <= '0;
      else
         flops_q <= flops_d;
   end

   // Committed window of the D-stage thread
   assign imd.imdctl_cwp_d     = 3'(cwp_q[thr_d]);
   assign imd.fcl_imd_oddwin_d = cwp_q[thr_d][0];

endmodule

// File: tb/tb_sparc_ifu_imdctl.sv
// Directed bench for sparc_ifu_imdctl: driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares.
module tb_sparc_ifu_imdctl;

   localparam logic [31:0] I_CALL   = 32'h4000_0010;
   localparam logic [31:0] I_SETHI  = 32'h0300_0001;
   localparam logic [31:0] I_MOVCC  = 32'h8160_0000;
   localparam logic [31:0] I_MOVR   = 32'h8178_0000;
   localparam logic [31:0] I_ADD    = 32'h8000_2001;
   localparam logic [31:0] I_BPR    = 32'h00C0_0000;
   localparam logic [31:0] I_BICC   = 32'h0080_0000;
   localparam logic [31:0] I_FBFCC  = 32'h0180_0000;
   localparam logic [31:0] I_BPCC   = 32'h0040_0000;
   localparam logic [31:0] I_FBPFCC = 32'h0140_0000;
   localparam logic [31:0] I_SAVE   = 32'h81E0_0000;
   localparam logic [31:0] I_REST   = 32'h81E8_0000;
   localparam logic [31:0] I_RETURN = 32'h81C8_0000;

   typedef struct {
      string       name;
      logic        chk_dec;
      logic [3:0]  imm_l;
      logic [3:0]  br_l;
      logic        immbr;
      logic        call;
      logic        stall;
      logic [2:0]  cwp;
   } exp_t;

   logic clk, reset, se, si, so;
   int   checks, errors;
   exp_t exp_q[$];

   sparc_ifu_imdctl_if bus ();

   sparc_ifu_imdctl dut (
      .rclk  (clk),
      .reset (reset),
      .se    (se),
      .si    (si),
      .so    (so),
      .imd   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one D-stage cycle just after the rising edge
   task automatic drive(input logic [31:0] inst, input logic vld, input logic [1:0] thr,
                        input logic fe = 1'b0, input logic fm = 1'b0, input logic rst = 1'b0,
                        input logic twv = 1'b0, input logic [1:0] twt = 2'd0,
                        input logic [2:0] twd = 3'd0);
      @(posedge clk);
      #1;
      reset                  = rst;
      bus.dtu_inst_d         = inst;
      bus.fcl_imdctl_vld_d   = vld;
      bus.fcl_imdctl_thr_d   = thr;
      bus.fcl_imdctl_flush_e = fe;
      bus.fcl_imdctl_flush_m = fm;
      bus.tlu_cwp_wr_vld     = twv;
      bus.tlu_cwp_wr_thr     = twt;
      bus.tlu_cwp_wr_data    = twd;
   endtask

   task automatic exp_dec(input string nm, input logic [3:0] imm, input logic [3:0] br,
                          input logic immbr, input logic call, input logic stall,
                          input logic [2:0] cwp);
      exp_t e;
      e = '{name: nm, chk_dec: 1'b1, imm_l: imm, br_l: br, immbr: immbr, call: call,
            stall: stall, cwp: cwp};
      exp_q.push_back(e);
   endtask

   task automatic exp_st(input string nm, input logic stall, input logic [2:0] cwp);
      exp_t e;
      e = '{name: nm, chk_dec: 1'b0, imm_l: 4'b0111, br_l: 4'b0111, immbr: 1'b0,
            call: 1'b0, stall: stall, cwp: cwp};
      exp_q.push_back(e);
   endtask

   // Monitor: one-hot invariant every cycle, then drain pending expectations
   always @(negedge clk) begin
      logic [3:0] imm_a, br_a;
      logic [4:0] st_a, st_e;
      logic [9:0] dec_a, dec_e;
      exp_t       e;
      imm_a = {bus.dcl_imd_immdata_sel_simm13_d_l, bus.dcl_imd_immdata_sel_movcc_d_l,
               bus.dcl_imd_immdata_sel_movr_d_l, bus.dcl_imd_immdata_sel_sethi_d_l};
      br_a  = {bus.dcl_imd_broff_sel_call_d_l, bus.dcl_imd_broff_sel_br_d_l,
               bus.dcl_imd_broff_sel_bcc_d_l, bus.dcl_imd_broff_sel_bpcc_d_l};
      checks++;
      if ($countones(~imm_a) != 1 || $countones(~br_a) != 1) begin
         errors++;
         $display("FAIL onehot t=%0t imm_l=%b br_l=%b required exactly one low each",
                  $time, imm_a, br_a);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         st_a = {bus.imdctl_stall_d, bus.imdctl_cwp_d, bus.fcl_imd_oddwin_d};
         st_e = {e.stall, e.cwp, e.cwp[0]};
         checks++;
         if (st_a !== st_e) begin
            errors++;
            $display("FAIL %s stall/cwp/odd actual=%b required=%b", e.name, st_a, st_e);
         end
         if (e.chk_dec) begin
            dec_a = {imm_a, br_a, bus.dcl_imd_immbr_sel_br_d, bus.dcl_imd_call_inst_d};
            dec_e = {e.imm_l, e.br_l, e.immbr, e.call};
            checks++;
            if (dec_a !== dec_e) begin
               errors++;
               $display("FAIL %s decode imm/br/immbr/call actual=%b required=%b",
                        e.name, dec_a, dec_e);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      se = 1'b0;
      si = 1'b0;
      reset = 1'b1;
      bus.dtu_inst_d = I_ADD;
      bus.fcl_imdctl_vld_d = 1'b0;
      bus.fcl_imdctl_thr_d = 2'd0;
      bus.fcl_imdctl_flush_e = 1'b0;
      bus.fcl_imdctl_flush_m = 1'b0;
      bus.tlu_cwp_wr_vld = 1'b0;
      bus.tlu_cwp_wr_thr = 2'd0;
      bus.tlu_cwp_wr_data = 3'd0;

      // Reset: valid ignored, decode still live
      drive(I_SAVE, 1, 0, .rst(1)); exp_dec("rst_dec", 4'b0111, 4'b0111, 0, 0, 0, 3'd0);
      drive(I_SAVE, 1, 1, .rst(1)); exp_st("rst_st", 0, 3'd0);

      // Decode table
      drive(I_CALL,   1, 0); exp_dec("call",   4'b0111, 4'b0111, 1, 1, 0, 3'd0);
      drive(I_SETHI,  1, 0); exp_dec("sethi",  4'b1110, 4'b0111, 0, 0, 0, 3'd0);
      drive(I_MOVCC,  1, 0); exp_dec("movcc",  4'b1011, 4'b0111, 0, 0, 0, 3'd0);
      drive(I_MOVR,   1, 0); exp_dec("movr",   4'b1101, 4'b0111, 0, 0, 0, 3'd0);
      drive(I_ADD,    1, 0); exp_dec("add",    4'b0111, 4'b0111, 0, 0, 0, 3'd0);
      drive(I_BPR,    1, 0); exp_dec("bpr",    4'b0111, 4'b1011, 1, 0, 0, 3'd0);
      drive(I_BICC,   1, 0); exp_dec("bicc",   4'b0111, 4'b1101, 1, 0, 0, 3'd0);
      drive(I_FBFCC,  1, 0); exp_dec("fbfcc",  4'b0111, 4'b1101, 1, 0, 0, 3'd0);
      drive(I_BPCC,   1, 0); exp_dec("bpcc",   4'b0111, 4'b1110, 1, 0, 0, 3'd0);
      drive(I_FBPFCC, 1, 0); exp_dec("fbpfcc", 4'b0111, 4'b1110, 1, 0, 0, 3'd0);

      // Thread 1 SAVE then same-thread ADD: stall cycles 1-3
      drive(I_SAVE, 1, 1); exp_st("a_save", 0, 3'd0);
      for (int i = 1; i <= 3; i++) begin
         drive(I_ADD, 1, 1); exp_st("a_stall", 1, 3'd0);
      end
      drive(I_ADD, 1, 1); exp_st("a_release", 0, 3'd1);

      // Thread 1 SAVE, other thread not stalled
      drive(I_SAVE, 1, 1); exp_st("b_save", 0, 3'd1);
      drive(I_ADD, 1, 2);  exp_st("b_thr2", 0, 3'd0);
      drive(I_ADD, 0, 1);  exp_st("b_idle", 0, 3'd1);
      drive(I_ADD, 0, 1);  exp_st("b_idle", 0, 3'd1);
      drive(I_ADD, 0, 1);  exp_st("b_commit", 0, 3'd2);

      // Back-to-back SAVE: stalled one must not enter E until released
      drive(I_SAVE, 1, 1); exp_st("c_save0", 0, 3'd2);
      for (int i = 1; i <= 3; i++) begin
         drive(I_SAVE, 1, 1); exp_st("c_stall", 1, 3'd2);
      end
      drive(I_SAVE, 1, 1); exp_st("c_save1", 0, 3'd3);
      for (int i = 5; i <= 7; i++) begin
         drive(I_ADD, 0, 1); exp_st("c_idle", 0, 3'd3);
      end
      drive(I_ADD, 0, 1); exp_st("c_commit", 0, 3'd4);

      // Thread 0 wrap: TLU sets 7, SAVE->0, RESTORE->7, RETURN->6
      drive(I_ADD, 0, 0, .twv(1), .twt(2'd0), .twd(3'd7)); exp_st("w_tlu", 0, 3'd0);
      drive(I_SAVE, 1, 0); exp_st("w_save", 0, 3'd7);
      for (int i = 1; i <= 3; i++) begin
         drive(I_ADD, 0, 0); exp_st("w_idle0", 0, 3'd7);
      end
      drive(I_REST, 1, 0); exp_st("w_wrap_up", 0, 3'd0);
      for (int i = 5; i <= 7; i++) begin
         drive(I_ADD, 0, 0); exp_st("w_idle1", 0, 3'd0);
      end
      drive(I_RETURN, 1, 0); exp_st("w_wrap_dn", 0, 3'd7);
      for (int i = 9; i <= 11; i++) begin
         drive(I_ADD, 0, 0); exp_st("w_idle2", 0, 3'd7);
      end
      drive(I_ADD, 0, 0); exp_st("w_return", 0, 3'd6);

      // Thread 3 SAVE killed in E
      drive(I_SAVE, 1, 3); exp_st("fe_save", 0, 3'd0);
      drive(I_ADD, 1, 3, .fe(1)); exp_st("fe_stall", 1, 3'd0);
      drive(I_ADD, 1, 3); exp_st("fe_drop", 0, 3'd0);
      drive(I_ADD, 0, 3); exp_st("fe_idle", 0, 3'd0);
      drive(I_ADD, 0, 3); exp_st("fe_nocommit", 0, 3'd0);

      // Thread 3 SAVE killed in M
      drive(I_SAVE, 1, 3); exp_st("fm_save", 0, 3'd0);
      drive(I_ADD, 1, 3); exp_st("fm_stall_e", 1, 3'd0);
      drive(I_ADD, 1, 3, .fm(1)); exp_st("fm_stall_m", 1, 3'd0);
      drive(I_ADD, 1, 3); exp_st("fm_drop", 0, 3'd0);
      drive(I_ADD, 0, 3); exp_st("fm_nocommit", 0, 3'd0);

      // Thread 2 RESTORE in W collides with TLU write to same thread
      drive(I_REST, 1, 2); exp_st("t_rest", 0, 3'd0);
      drive(I_ADD, 0, 2);  exp_st("t_idle", 0, 3'd0);
      drive(I_ADD, 0, 2);  exp_st("t_idle", 0, 3'd0);
      drive(I_ADD, 0, 2, .twv(1), .twt(2'd2), .twd(3'd5)); exp_st("t_wr_same", 0, 3'd0);
      drive(I_ADD, 0, 2);  exp_st("t_tlu_wins", 0, 3'd5);

      // Same with TLU write to another thread: both update
      drive(I_REST, 1, 2); exp_st("u_rest", 0, 3'd5);
      drive(I_ADD, 0, 2);  exp_st("u_idle", 0, 3'd5);
      drive(I_ADD, 0, 2);  exp_st("u_idle", 0, 3'd5);
      drive(I_ADD, 0, 2, .twv(1), .twt(2'd0), .twd(3'd5)); exp_st("u_wr_other", 0, 3'd5);
      drive(I_ADD, 0, 2);  exp_st("u_thr2_dec", 0, 3'd4);
      drive(I_ADD, 0, 0);  exp_st("u_thr0_tlu", 0, 3'd5);

      // Reset mid-flight discards pending SAVE and clears windows
      drive(I_SAVE, 1, 1); exp_st("r_save", 0, 3'd4);
      drive(I_ADD, 1, 1, .rst(1)); exp_st("r_in_reset", 0, 3'd4);
      drive(I_ADD, 1, 1); exp_st("r_after", 0, 3'd0);
      drive(I_ADD, 0, 0); exp_st("r_thr0", 0, 3'd0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
